rn_release_seq: RTL and testbench
=================================

RN_RELEASE_SEQ -- requirements
Module: rn_release_seq

Interface
REQ-001: Parameter N_GRP, default 4, number of independently released reset groups (legal 1..16).
REQ-002: Parameter HOLD_CYC, default 8, cycles all groups stay in reset after a reset event (legal 1..255).
REQ-003: Parameter GAP_CYC, default 2, cycles between consecutive group releases (legal 1..255).
REQ-004: CLK  input  1  rising-edge clock; sole clock of the block.
REQ-005: RST  input  1  reset, synchronous, active-high; sampled only on CLK rising edge.
REQ-006: REQ  input  1  software reset request, level sampled each edge, active-high.
REQ-007: RN  output  N_GRP  active-low reset per group, registered, drives RN pins of downstream dffrnq flops.
REQ-008: BUSY  output  1  high while any RN bit is 0 or a sequence is in progress.
REQ-009: DONE  output  1  single-cycle pulse on sequence completion.

Function
REQ-010: The block SHALL implement three states: ASSERT, RELEASE, IDLE.
REQ-011: All outputs SHALL be driven directly from flops; no combinational path from REQ or RST to any output.
REQ-012: In ASSERT, RN SHALL be all zeros and a hold counter SHALL increment once per edge.
REQ-013: ASSERT SHALL transition to RELEASE on the edge where the hold counter reaches HOLD_CYC; on that same edge RN[0] SHALL go to 1.
REQ-014: In RELEASE, a gap counter SHALL count edges; every GAP_CYC edges the next group index SHALL be released (RN[i] to 1).
REQ-015: RN SHALL be thermometer-coded at all times: RN[i]=1 implies RN[j]=1 for all j<i.
REQ-016: On the edge that sets RN[N_GRP-1] to 1, state SHALL go to IDLE, BUSY SHALL go to 0 and DONE SHALL go to 1 for exactly one cycle.
REQ-017: With N_GRP=1, RELEASE SHALL complete on the same edge as the ASSERT exit (DONE coincident with RN[0] rising).
REQ-018: In IDLE, RN SHALL be all ones, BUSY 0, DONE 0 except the completion cycle.
REQ-019: REQ=1 in IDLE SHALL move to ASSERT on that edge: RN all zeros, BUSY 1, hold counter 0.
REQ-020: REQ=1 in ASSERT SHALL restart the hold counter at 0 (hold extended while REQ held).
REQ-021: REQ=1 in RELEASE SHALL abort: next edge RN all zeros, state ASSERT, hold counter 0, no DONE pulse.
REQ-022: REQ=1 on the completion edge SHALL take precedence: state ASSERT, RN all zeros, DONE 0.
REQ-023: Counter widths SHALL be 8 bits for hold/gap and ceil(log2(N_GRP))+1 bits for the group index; no counter SHALL wrap.

Reset
REQ-024: RST=1 at an edge SHALL force state ASSERT, RN all zeros, BUSY 1, DONE 0, all counters 0, overriding REQ and any state.
REQ-025: RST held high SHALL keep the block in that reset state; the hold count starts at the first edge with RST=0.
REQ-026: RST asserted mid-RELEASE SHALL re-assert all RN bits on that edge with no DONE pulse.

Verification
REQ-027: Defaults, RST high 3 edges then low; counting edges with RST=0 from 1 -> RN[0] rises at edge 8, RN[1] 10, RN[2] 12, RN[3] 14, DONE high for the cycle after edge 14 only, BUSY low after edge 14.
REQ-028: IDLE, REQ pulsed 1 cycle -> next edge RN=4'b0000, BUSY=1; RN=4'b1111 and DONE pulse exactly 14 edges after the REQ edge.
REQ-029: REQ asserted at edge 11 of the post-reset sequence (RN=4'b0011) -> edge 11 RN=4'b0000, no DONE; full sequence then restarts, RN[0] rising 8 edges later.
REQ-030: REQ held high 20 edges in ASSERT -> RN stays 4'b0000 throughout; RN[0] rises 8 edges after REQ falls.
REQ-031: RST and REQ both high in IDLE, then RST mid-RELEASE -> both cases RN=4'b0000, BUSY=1, DONE=0 on that edge; thermometer property and single-cycle DONE checked by assertion over a random REQ/RST run of 10k cycles.
REQ-032: N_GRP=1, HOLD_CYC=1, GAP_CYC=1 build -> RN[0] rises and DONE pulses on the first edge with RST=0.

Source files
------------

// File: rtl/rn_release_seq.sv
// -----------------------------------------------------------------------------
// rn_release_seq
//
// Staged reset-release sequencer. After a reset event (RST or a software
// request) every group's active-low reset is held low for HOLD_CYC clock
// edges. The groups are then released one at a time, lowest index first,
// with GAP_CYC edges between releases. The RN vector is always
// thermometer-coded, so group i is never out of reset while a lower group
// is still held.
//
// Ports:
//   CLK   in   1      rising-edge clock, sole clock of the block
//   RST   in   1      synchronous active-high reset (sampled on CLK rise)
//   REQ   in   1      software reset request, level-sampled, active-high
//   RN    out  N_GRP  active-low reset per group, registered
//   BUSY  out  1      high while any group is still held or releasing
//   DONE  out  1      one-cycle pulse when the last group is released
//
// Parameters:
//   N_GRP     number of reset groups            (1..16)
//   HOLD_CYC  edges all groups are held low     (1..255)
//   GAP_CYC   edges between successive releases (1..255)
// -----------------------------------------------------------------------------
module rn_release_seq #(
  parameter int N_GRP    = 4,
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  output logic [N_GRP-1:0] RN,
  output logic             BUSY,
  output logic             DONE
);

  // The group counter holds the number of released groups, so it must be able
  // to represent N_GRP itself (hence the extra bit).
  localparam int GW = $clog2(N_GRP) + 1;

  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYC);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYC);
  localparam logic [GW-1:0] GRP_ALL   = GW'(N_GRP);
  localparam logic [GW-1:0] GRP_ONE   = GW'(1);
  localparam logic [GW-1:0] GRP_ZERO  = GW'(0);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q,  hold_d;
  logic [7:0]       gap_q,   gap_d;
  logic [GW-1:0]    grp_q,   grp_d;
  logic [N_GRP-1:0] rn_q,    rn_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Thermometer code: the lowest 'cnt' groups are released (bit = 1).
  function automatic logic [N_GRP-1:0] therm(input logic [GW-1:0] cnt);
    logic [N_GRP-1:0] t;
    t = '0;
    for (int i = 0; i < N_GRP; i++) begin
      if (int'(cnt) > i) begin
        t[i] = 1'b1;
      end else begin
        t[i] = 1'b0;
      end
    end
    return t;
  endfunction

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    grp_d   = grp_q;
    done_d  = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        if (REQ) begin
          // A request while holding simply stretches the hold.
          hold_d = 8'd0;
        end else if ((hold_q + 8'd1) == HOLD_LAST) begin
          // Hold expires: group 0 is released on this same edge. With a
          // single group that is also the completion edge.
          hold_d = HOLD_LAST;
          gap_d  = 8'd0;
          grp_d  = GRP_ONE;
          if (GRP_ALL == GRP_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        if (REQ) begin
          // Abort: every group goes back into reset, no completion pulse.
          // This also covers a request on the would-be completion edge.
          state_d = ST_ASSERT;
          hold_d  = 8'd0;
          gap_d   = 8'd0;
          grp_d   = GRP_ZERO;
        end else if ((gap_q + 8'd1) == GAP_LAST) begin
          gap_d = 8'd0;
          grp_d = grp_q + GRP_ONE;
          if ((grp_q + GRP_ONE) == GRP_ALL) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (REQ) begin
          state_d = ST_ASSERT;
          hold_d  = 8'd0;
          gap_d   = 8'd0;
          grp_d   = GRP_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // Unreachable encoding: recover by re-entering the hold phase.
        state_d = ST_ASSERT;
        hold_d  = 8'd0;
        gap_d   = 8'd0;
        grp_d   = GRP_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    rn_d   = therm(grp_d);
  end

  // State, counter and output registers; RST overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ASSERT;
      hold_q  <= 8'd0;
      gap_q   <= 8'd0;
      grp_q   <= GRP_ZERO;
      rn_q    <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      grp_q   <= grp_d;
      rn_q    <= rn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RN   = rn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_rn_release_seq.sv
// -----------------------------------------------------------------------------
// tb_rn_release_seq
//
// Two instances share RST/REQ: the default build (4 groups, hold 8, gap 2)
// and a minimal build (1 group, hold 1, gap 1). A reference model predicts
// both from one number per instance: the count of clean edges (RST=0, REQ=0)
// since the last reset event. From that count the number of released groups
// follows by arithmetic, and DONE is the edge where that count first reaches
// full release.
// -----------------------------------------------------------------------------
module tb_rn_release_seq;

  localparam int NA = 4, HA = 8, GA = 2;
  localparam int NB = 1, HB = 1, GB = 1;
  localparam int TA = HA + (NA - 1) * GA;  // clean edges to completion
  localparam int TB = HB + (NB - 1) * GB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ = 1'b0;
  logic [NA-1:0] rn_a;
  logic          busy_a, done_a;
  logic [NB-1:0] rn_b;
  logic          busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int k_a     = 0;
  int k_b     = 0;

  typedef struct {
    logic       rst;
    logic       req;
    logic [3:0] rn;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[18];

  always #5 CLK = ~CLK;

  rn_release_seq #(.N_GRP(NA), .HOLD_CYC(HA), .GAP_CYC(GA)) dut_a (
    .CLK(CLK), .RST(RST), .REQ(REQ), .RN(rn_a), .BUSY(busy_a), .DONE(done_a)
  );

  rn_release_seq #(.N_GRP(NB), .HOLD_CYC(HB), .GAP_CYC(GB)) dut_b (
    .CLK(CLK), .RST(RST), .REQ(REQ), .RN(rn_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Released groups after k clean edges.
  function automatic int rel_cnt(int k, int n, int h, int g);
    int r;
    if (k < h) return 0;
    r = 1 + (k - h) / g;
    return (r > n) ? n : r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one edge, advance the model, compare both instances.
  task automatic step(input logic rst, input logic req);
    int ra, rb;
    @(negedge CLK);
    RST = rst;
    REQ = req;
    @(posedge CLK);
    #1;
    if (rst || req) begin
      k_a = 0;
      k_b = 0;
    end else begin
      if (k_a <= TA) k_a++;
      if (k_b <= TB) k_b++;
    end
    ra = rel_cnt(k_a, NA, HA, GA);
    rb = rel_cnt(k_b, NB, HB, GB);
    check("model_rn_a",   int'(rn_a),   (1 << ra) - 1);
    check("model_busy_a", int'(busy_a), (ra < NA) ? 1 : 0);
    check("model_done_a", int'(done_a), (k_a == TA) ? 1 : 0);
    check("model_rn_b",   int'(rn_b),   (1 << rb) - 1);
    check("model_busy_b", int'(busy_b), (rb < NB) ? 1 : 0);
    check("model_done_b", int'(done_b), (k_b == TB) ? 1 : 0);
  endtask

  initial begin
    logic prev_done_a, prev_done_b;
    logic r_rst, r_req;

    // Power-up sequence: 3 reset edges then clean edges 1..15.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    for (int e = 1; e <= 15; e++) begin
      logic [3:0] r;
      if (e < 8)       r = 4'b0000;
      else if (e < 10) r = 4'b0001;
      else if (e < 12) r = 4'b0011;
      else if (e < 14) r = 4'b0111;
      else             r = 4'b1111;
      tbl[e + 2] = '{1'b0, 1'b0, r, (e < 14) ? 1'b1 : 1'b0, (e == 14) ? 1'b1 : 1'b0};
    end

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].req);
      check("tbl_rn",   int'(rn_a),   int'(tbl[i].rn));
      check("tbl_busy", int'(busy_a), int'(tbl[i].busy));
      check("tbl_done", int'(done_a), int'(tbl[i].done));
    end

    // Single-cycle request from IDLE: completion 14 edges later.
    step(1'b0, 1'b1);
    check("req_idle_rn",   int'(rn_a),   0);
    check("req_idle_busy", int'(busy_a), 1);
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, 1'b0);
      check("req_idle_done", int'(done_a), (j == 14) ? 1 : 0);
    end
    check("req_idle_rn_end", int'(rn_a), 15);

    // Abort mid-release at clean edge 11 (RN=0011).
    step(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b0);
    check("pre_abort_rn", int'(rn_a), 3);
    step(1'b0, 1'b1);
    check("abort_rn",   int'(rn_a),   0);
    check("abort_done", int'(done_a), 0);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 1'b0);
      check("abort_restart_rn", int'(rn_a), (j == 8) ? 1 : 0);
    end

    // REQ held 20 edges in ASSERT stretches the hold.
    step(1'b1, 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b1);
      check("req_hold_rn", int'(rn_a), 0);
    end
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, 1'b0);
      if (j <= 8) check("req_hold_release", int'(rn_a), (j == 8) ? 1 : 0);
    end
    check("req_hold_idle_busy", int'(busy_a), 0);

    // RST and REQ together in IDLE, then RST mid-RELEASE.
    step(1'b1, 1'b1);
    check("rst_req_rn",   int'(rn_a),   0);
    check("rst_req_busy", int'(busy_a), 1);
    check("rst_req_done", int'(done_a), 0);
    for (int e = 1; e <= 9; e++) step(1'b0, 1'b0);
    check("mid_rel_rn", int'(rn_a), 1);
    step(1'b1, 1'b0);
    check("rst_mid_rn",   int'(rn_a),   0);
    check("rst_mid_busy", int'(busy_a), 1);
    check("rst_mid_done", int'(done_a), 0);

    // Minimal build completes on the first clean edge.
    step(1'b0, 1'b0);
    check("min_rn",   int'(rn_b),   1);
    check("min_done", int'(done_b), 1);
    check("min_busy", int'(busy_b), 0);

    // Random REQ/RST run with invariant checks on top of the model.
    prev_done_a = done_a;
    prev_done_b = done_b;
    for (int c = 0; c < 10000; c++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_req = ($urandom_range(0, 39) == 0);
      step(r_rst, r_req);
      check("therm_a", int'((rn_a & (rn_a + 4'd1)) == 4'd0), 1);
      if (prev_done_a) check("done_pulse_a", int'(done_a), 0);
      if (prev_done_b) check("done_pulse_b", int'(done_b), 0);
      prev_done_a = done_a;
      prev_done_b = done_b;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
